// File: rtl/func_gen_pkg.sv
// Shared definitions for the function generator and its sweep sequencer:
// FSM encoding, amplitude/wave codes, frequency ceiling and config checking.
package func_gen_pkg;

  localparam int F_MAX = 50000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DWELL  = 3'd2,
    ST_STEP   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] AMP_1V  = 3'b000;
  localparam logic [2:0] AMP_2V  = 3'b001;
  localparam logic [2:0] AMP_5V  = 3'b010;
  localparam logic [2:0] AMP_10V = 3'b011;
  localparam logic [2:0] AMP_15V = 3'b100;
  localparam logic [2:0] AMP_20V = 3'b101;

  localparam logic WAVE_SIN = 1'b0;
  localparam logic WAVE_COS = 1'b1;

  function automatic logic cfg_illegal(input logic [18:0] fs, input logic [18:0] fe,
                                       input logic [18:0] st, input logic [15:0] dw,
                                       input logic [2:0]  a,  input logic [18:0] fmax);
    return (fs == '0) || (fs > fe) || (fe > fmax) || (st == '0) || (dw == '0) ||
           (a > AMP_20V);
  endfunction

endpackage

// File: rtl/smp_cnt.sv
// Sample-clock edge detector and counter. An edge detected in cycle t is
// counted in t+1; hit pulses in that counting cycle when the count reaches target.
module smp_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_clk,
  input  logic        clr,
  input  logic [15:0] target,
  output logic        hit
);

  logic        s_clk_q;
  logic        edge_q;
  logic [15:0] cnt_q;
  logic [16:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign hit     = edge_q && !clr && (cnt_inc == {1'b0, target});

  always_ff @(posedge clk) begin
    if (rst) begin
      s_clk_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s_clk_q <= s_clk;
      // Edges seen while cleared or on the hit cycle belong to the old window.
      if (clr || hit) begin
        edge_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        edge_q <= s_clk & ~s_clk_q;
        if (edge_q) cnt_q <= cnt_inc[15:0];
      end
    end
  end

endmodule

// File: rtl/func_gen_sweep_ctrl.sv
// Stepped frequency sweep sequencer for func_gen: per point it settles for
// SETTLE_SMP sample edges, then opens a meas_en window of dwell edges.
module func_gen_sweep_ctrl #(
  parameter int SETTLE_SMP = 64,
  parameter int F_MAX      = func_gen_pkg::F_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_clk,
  input  logic        start,
  input  logic        abort,
  input  logic [18:0] f_start,
  input  logic [18:0] f_stop,
  input  logic [18:0] f_step,
  input  logic [15:0] dwell,
  input  logic        w_cfg,
  input  logic [2:0]  a_cfg,
  output logic [18:0] f_set,
  output logic        w_set,
  output logic [2:0]  a_set,
  output logic        meas_en,
  output logic [11:0] step_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  import func_gen_pkg::*;

  localparam logic [18:0] FMAX_W   = 19'(F_MAX);
  localparam logic [15:0] SETTLE_W = 16'(SETTLE_SMP);

  state_e      state_q, state_d;
  logic [18:0] f_stop_q, f_stop_d;
  logic [18:0] f_step_q, f_step_d;
  logic [15:0] dwell_q, dwell_d;
  logic [18:0] f_set_q, f_set_d;
  logic        w_set_q, w_set_d;
  logic [2:0]  a_set_q, a_set_d;
  logic [11:0] step_idx_q, step_idx_d;
  logic        meas_en_q, meas_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        cnt_clr;
  logic [15:0] cnt_target;
  logic        hit;
  logic [19:0] nxt;

  assign cnt_clr    = !(state_q == ST_SETTLE || state_q == ST_DWELL);
  assign cnt_target = (state_q == ST_DWELL) ? dwell_q : SETTLE_W;
  assign nxt        = {1'b0, f_set_q} + {1'b0, f_step_q};

  smp_cnt u_smp_cnt (
    .clk    (clk),
    .rst    (rst),
    .s_clk  (s_clk),
    .clr    (cnt_clr),
    .target (cnt_target),
    .hit    (hit)
  );

  always_comb begin
    state_d    = state_q;
    f_stop_d   = f_stop_q;
    f_step_d   = f_step_q;
    dwell_d    = dwell_q;
    f_set_d    = f_set_q;
    w_set_d    = w_set_q;
    a_set_d    = a_set_q;
    step_idx_d = step_idx_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_illegal(f_start, f_stop, f_step, dwell, a_cfg, FMAX_W)) begin
            err_d = 1'b1;
          end else begin
            f_stop_d   = f_stop;
            f_step_d   = f_step;
            dwell_d    = dwell;
            f_set_d    = f_start;
            w_set_d    = w_cfg;
            a_set_d    = a_cfg;
            step_idx_d = '0;
            state_d    = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: if (hit) state_d = ST_DWELL;
      ST_DWELL:  if (hit) state_d = ST_STEP;
      ST_STEP: begin
        if (f_set_q == f_stop_q) begin
          state_d = ST_DONE;
        end else begin
          // 20-bit sum so a huge step past the 19-bit range still clamps.
          f_set_d = (nxt > {1'b0, f_stop_q}) ? f_stop_q : nxt[18:0];
          if (step_idx_q != 12'hFFF) step_idx_d = step_idx_q + 12'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      f_set_d = '0;
      w_set_d = 1'b0;
      a_set_d = '0;
    end

    busy_d    = (state_d != ST_IDLE);
    meas_en_d = (state_d == ST_DWELL);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      dwell_q    <= '0;
      f_set_q    <= '0;
      w_set_q    <= 1'b0;
      a_set_q    <= '0;
      step_idx_q <= '0;
      meas_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_stop_q   <= f_stop_d;
      f_step_q   <= f_step_d;
      dwell_q    <= dwell_d;
      f_set_q    <= f_set_d;
      w_set_q    <= w_set_d;
      a_set_q    <= a_set_d;
      step_idx_q <= step_idx_d;
      meas_en_q  <= meas_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign f_set    = f_set_q;
  assign w_set    = w_set_q;
  assign a_set    = a_set_q;
  assign meas_en  = meas_en_q;
  assign step_idx = step_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/func_gen_sweep_ctrl.md
# func_gen_sweep_ctrl

Sequencer that drives the function generator's configuration inputs (`f_set`, `w_set`, `a_set`) through a stepped frequency sweep for characterising the FIR filters. At each frequency point it waits a programmable settling interval, then asserts a measurement window for a programmed number of samples. It sits between the host/test register block and `func_gen`, and paces itself on the same `s_clk` sample clock.

## Interface
Parameters:
- `SETTLE_SMP`, 64: sample edges discarded after every frequency change (covers the FIR group delay).
- `F_MAX`, 50000: highest legal frequency in Hz.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_clk` in 1: sample clock level, synchronous to `clk`. Its rising edge is detected internally with one register.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `abort` in 1: one-cycle request; terminates the sweep.
- `f_start` in 19: first frequency (Hz).
- `f_stop` in 19: last frequency (Hz).
- `f_step` in 19: frequency increment (Hz).
- `dwell` in 16: measurement samples per point.
- `w_cfg` in 1: wave type (0 = sin, 1 = cos).
- `a_cfg` in 3: amplitude code (000 to 101).
- `f_set` out 19: frequency to `func_gen`.
- `w_set` out 1: wave type to `func_gen`.
- `a_set` out 3: amplitude to `func_gen`.
- `meas_en` out 1: high while the current point is valid for measurement.
- `step_idx` out 12: index of the current point, starting at 0.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes normally.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, SETTLE, DWELL, STEP, DONE.
- **IDLE, `start`=1, config legal:**
  - Latch `f_start`, `f_stop`, `f_step`, `dwell`, `w_cfg`, `a_cfg`.
  - Next cycle: `f_set`=`f_start`, `w_set`/`a_set` take the latched values, `step_idx`=0, `busy`=1. Go to SETTLE.
- **Illegal config:** any of `f_start`=0, `f_start`>`f_stop`, `f_stop`>F_MAX, `f_step`=0, `dwell`=0, `a_cfg`>3'b101.
  - `err` pulses for one cycle and the block stays in IDLE. Outputs are unchanged.
- **SETTLE:** count SETTLE_SMP `s_clk` rising edges with `meas_en`=0, then go to DWELL.
- **DWELL:** `meas_en`=1. Count `dwell` `s_clk` rising edges, then go to STEP.
- **STEP:** one cycle, `meas_en`=0. Compute `nxt` = `f_set` + `f_step` in 20-bit unsigned arithmetic.
  - If `f_set`=`f_stop`: go to DONE.
  - Else if `nxt` > `f_stop`: `f_set`=`f_stop` (final point clamped). Increment `step_idx` and go to SETTLE.
  - Else: `f_set`=`nxt[18:0]`. Increment `step_idx` and go to SETTLE.
- **DONE:** one cycle with `done`=1, then IDLE. In IDLE, `busy`=0 and `f_set`/`w_set`/`a_set` hold their last values.
- **`abort` in any non-IDLE state:**
  - Next cycle: IDLE with `meas_en`=0, `busy`=0, and `f_set`=0, `w_set`=0, `a_set`=0. No `done` pulse.
  - `abort` has priority over every other transition in that cycle.
- `start` outside IDLE is ignored. Input config changes during a sweep have no effect.
- `step_idx` saturates at 4095. It keeps the sweep running; it does not wrap.

## Timing
- Reset values: `f_set`=0, `w_set`=0, `a_set`=0, `meas_en`=0, `step_idx`=0, `busy`=0, `done`=0, `err`=0. State is IDLE and counters are 0.
- `rst` mid-sweep behaves like `abort`, and also clears `step_idx`.
- All outputs are registered.
- Latency:
  - `start` to `busy`/`f_set` valid: 1 cycle.
  - `err` is asserted 1 cycle after a rejected `start`.
- Sample counting: an `s_clk` edge is counted in the `clk` cycle after it is detected.
  - The first counted edge of SETTLE is the first detected edge at or after the SETTLE entry cycle.
  - `meas_en` rises in the cycle after the SETTLE_SMP-th edge.
  - `meas_en` falls in the cycle after the `dwell`-th DWELL edge.
- `meas_en` covers exactly `dwell` sample edges per point.
- Per-point duration: (SETTLE_SMP + `dwell`) sample periods + 1 STEP cycle + edge-alignment slack (< 1 sample period).

## Structure
- Shared package `func_gen_pkg`:
  - state encoding constants;
  - amplitude codes AMP_1V to AMP_20V (000 to 101);
  - WAVE_SIN/WAVE_COS;
  - F_MAX.
- Sub-module `smp_cnt`:
  - `s_clk` edge detector plus 16-bit sample counter;
  - inputs `clk`, `rst`, `s_clk`, `clr`, `target`;
  - output `hit` (one-cycle pulse on reaching `target`).
- The top level holds the FSM, config latches and the 20-bit step adder.

## Test plan
- Nominal sweep: `f_start`=1000, `f_stop`=5000, `f_step`=1000, `dwell`=8, SETTLE_SMP=4 -> `f_set` visits 1000/2000/3000/4000/5000, `step_idx` 0 to 4, 8 sample edges of `meas_en` per point, single `done` pulse, `busy` low afterwards.
- Clamp: `f_start`=1000, `f_stop`=3500, `f_step`=1000 -> points 1000/2000/3000/3500, then `done`.
- Rejection: `f_step`=0; also `f_start`=6000 with `f_stop`=5000; also `a_cfg`=3'b110 -> `err` pulse each time, `busy` stays 0, outputs unchanged.
- Abort during DWELL of point 2 -> next cycle `busy`=0, `meas_en`=0, `f_set`=0, no `done`; a new `start` is accepted normally.
- `start` pulsed mid-sweep, with inputs changed to `f_step`=7 -> ignored; the sweep continues with the latched step.
- Single point: `f_start`=`f_stop`=50000 -> one SETTLE/DWELL, `step_idx`=0, `done`. `f_stop`=50001 -> `err`.
